// File: rtl/ipg_msg_pkg.sv
// Shared constants for the IPG message scheduler: opcodes, chunk layout,
// reply FSM states and the reply header builder.
package ipg_msg_pkg;

  localparam logic [7:0] OP_REPLY = 8'h02;

  localparam int CHUNK_W = 64;
  localparam int OP_LSB = 56;
  localparam int OP_W = 8;
  localparam int TAG_LSB = 48;
  localparam int TAG_W = 8;
  localparam int LEN_LSB = 40;
  localparam int LEN_W = 8;
  localparam int SEQ_LSB = 32;
  localparam int SEQ_W = 8;
  localparam int ADDR_W = 40;
  localparam int SADDR_W = 32;

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  function automatic logic [CHUNK_W-1:0] reply_hdr(
    input logic [TAG_W-1:0] tag,
    input logic [LEN_W-1:0] len
  );
    return {OP_REPLY, tag, len, {ADDR_W{1'b0}}};
  endfunction

endpackage

// File: rtl/ipg_tag_pool.sv
// Request tag pool: free bitmap, lowest-free allocation, free count and
// sticky error for releasing a tag that is already free.
module ipg_tag_pool #(
  parameter int TAG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc,
  input  logic                 rel_valid,
  input  logic [TAG_WIDTH-1:0] rel_tag,
  output logic [TAG_WIDTH-1:0] alloc_tag,
  output logic [TAG_WIDTH:0]   tags_free,
  output logic                 tag_err
);

  localparam int N = 1 << TAG_WIDTH;

  logic [N-1:0] free_map;
  logic [N-1:0] free_map_n;
  logic         rel_ok;
  logic         rel_bad;

  // Scan downward so the last hit is the lowest free index.
  always_comb begin
    alloc_tag = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (free_map[i]) begin
        alloc_tag = TAG_WIDTH'(i);
      end
    end
  end

  assign rel_ok = rel_valid & ~free_map[rel_tag];
  assign rel_bad = rel_valid & free_map[rel_tag];

  // Allocation works on the pre-release map, so a tag freed this
  // cycle can only be handed out from the next cycle on.
  always_comb begin
    free_map_n = free_map;
    if (alloc) begin
      free_map_n[alloc_tag] = 1'b0;
    end
    if (rel_ok) begin
      free_map_n[rel_tag] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      free_map <= '1;
      tags_free <= (TAG_WIDTH + 1)'(N);
      tag_err <= 1'b0;
    end else begin
      free_map <= free_map_n;
      unique case ({alloc, rel_ok})
        2'b10: tags_free <= tags_free - (TAG_WIDTH + 1)'(1);
        2'b01: tags_free <= tags_free + (TAG_WIDTH + 1)'(1);
        default: tags_free <= tags_free;
      endcase
      if (rel_bad) begin
        tag_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ipg_msg_sched.sv
// IPG message scheduler: request/reply chunk formatting with tx_pause gating.
// Define IPG_MSG_SEQ_EN to carry a request sequence number in bits [39:32].
module ipg_msg_sched
  import ipg_msg_pkg::*;
#(
  parameter int         TAG_WIDTH = 4,
  parameter logic [7:0] REQ_OPCODE_MASK = 8'hFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [7:0]           req_opcode,
  input  logic [39:0]          req_addr,
  input  logic [7:0]           req_len,
  input  logic                 rep_valid,
  output logic                 rep_ready,
  input  logic [63:0]          rep_data,
  input  logic                 rep_last,
  input  logic [7:0]           rep_tag,
  input  logic [7:0]           rep_len,
  input  logic                 tag_rel_valid,
  input  logic [TAG_WIDTH-1:0] tag_rel,
  input  logic                 tx_pause,
  output logic [63:0]          ipg_req_chunk,
  output logic                 reqq_write,
  output logic [63:0]          ipg_reply_chunk,
  output logic                 memq_write,
  output logic [TAG_WIDTH:0]   tags_free,
  output logic                 rep_len_err,
  output logic                 tag_err
);

  logic                 req_fire;
  logic [TAG_WIDTH-1:0] alloc_tag;
  logic [TAG_W-1:0]     tag8;
  logic [CHUNK_W-1:0]   req_chunk_d;

  assign req_ready = !tx_pause && (tags_free != '0);
  assign req_fire = req_valid & req_ready;
  assign tag8 = TAG_W'(alloc_tag);

  ipg_tag_pool #(
    .TAG_WIDTH (TAG_WIDTH)
  ) u_pool (
    .clk       (clk),
    .rst       (rst),
    .alloc     (req_fire),
    .rel_valid (tag_rel_valid),
    .rel_tag   (tag_rel),
    .alloc_tag (alloc_tag),
    .tags_free (tags_free),
    .tag_err   (tag_err)
  );

`ifdef IPG_MSG_SEQ_EN
  logic [SEQ_W-1:0] seq;

  always_ff @(posedge clk) begin
    if (rst) begin
      seq <= '0;
    end else if (req_fire) begin
      seq <= seq + SEQ_W'(1);
    end
  end

  assign req_chunk_d = {req_opcode & REQ_OPCODE_MASK, tag8, req_len,
                        seq, req_addr[SADDR_W-1:0]};
`else
  assign req_chunk_d = {req_opcode & REQ_OPCODE_MASK, tag8, req_len,
                        req_addr};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      reqq_write <= 1'b0;
      ipg_req_chunk <= '0;
    end else begin
      reqq_write <= req_fire;
      if (req_fire) begin
        ipg_req_chunk <= req_chunk_d;
      end
    end
  end

  logic [0:0]       state;
  logic [LEN_W-1:0] len_q;
  logic [8:0]       cnt;
  logic [8:0]       cnt_inc;
  logic             hdr_fire;
  logic             beat_fire;

  assign rep_ready = (state == R_DATA) && !tx_pause;
  assign beat_fire = rep_valid & rep_ready;
  assign hdr_fire = (state == R_IDLE) && rep_valid && !tx_pause;

  // Saturate past 255 so an over-long stream can never wrap into a match.
  assign cnt_inc = cnt[8] ? cnt : cnt + 9'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= R_IDLE;
      len_q <= '0;
      cnt <= '0;
      memq_write <= 1'b0;
      ipg_reply_chunk <= '0;
      rep_len_err <= 1'b0;
    end else begin
      memq_write <= hdr_fire | beat_fire;
      unique case (1'b1)
        hdr_fire: begin
          ipg_reply_chunk <= reply_hdr(rep_tag, rep_len);
          len_q <= rep_len;
          cnt <= '0;
          state <= R_DATA;
        end
        beat_fire: begin
          ipg_reply_chunk <= rep_data;
          cnt <= cnt_inc;
          if (rep_last) begin
            state <= R_IDLE;
            if (cnt_inc != {1'b0, len_q}) begin
              rep_len_err <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ipg_msg_sched.sv
// Randomised and directed bench for ipg_msg_sched against a
// transaction-level reference model held in plain arrays and counters.
module tb_ipg_msg_sched;

  localparam logic [7:0] MASK = 8'hFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_opcode;
  logic [39:0] req_addr;
  logic [7:0]  req_len;
  logic        rep_valid;
  logic        rep_ready;
  logic [63:0] rep_data;
  logic        rep_last;
  logic [7:0]  rep_tag;
  logic [7:0]  rep_len;
  logic        tag_rel_valid;
  logic [3:0]  tag_rel;
  logic        tx_pause;
  logic [63:0] ipg_req_chunk;
  logic        reqq_write;
  logic [63:0] ipg_reply_chunk;
  logic        memq_write;
  logic [4:0]  tags_free;
  logic        rep_len_err;
  logic        tag_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ipg_msg_sched #(
    .TAG_WIDTH       (4),
    .REQ_OPCODE_MASK (MASK)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_opcode      (req_opcode),
    .req_addr        (req_addr),
    .req_len         (req_len),
    .rep_valid       (rep_valid),
    .rep_ready       (rep_ready),
    .rep_data        (rep_data),
    .rep_last        (rep_last),
    .rep_tag         (rep_tag),
    .rep_len         (rep_len),
    .tag_rel_valid   (tag_rel_valid),
    .tag_rel         (tag_rel),
    .tx_pause        (tx_pause),
    .ipg_req_chunk   (ipg_req_chunk),
    .reqq_write      (reqq_write),
    .ipg_reply_chunk (ipg_reply_chunk),
    .memq_write      (memq_write),
    .tags_free       (tags_free),
    .rep_len_err     (rep_len_err),
    .tag_err         (tag_err)
  );

  // Reference model state
  bit          mfree[16];
  int          mnfree;
  bit          m_in_data;
  int          m_len;
  int          m_cnt;
  bit          m_lerr;
  bit          m_terr;
  int          m_seq;
  bit          e_reqq;
  bit          e_memq;
  logic [63:0] e_req_chunk;
  logic [63:0] e_rep_chunk;
  bit          m_hdr;
  bit          m_beat;

  function automatic void mreset();
    for (int i = 0; i < 16; i++) mfree[i] = 1'b1;
    mnfree = 16;
    m_in_data = 1'b0;
    m_len = 0;
    m_cnt = 0;
    m_lerr = 1'b0;
    m_terr = 1'b0;
    m_seq = 0;
    e_reqq = 1'b0;
    e_memq = 1'b0;
    e_req_chunk = '0;
    e_rep_chunk = '0;
  endfunction

  function automatic int lowest_free();
    for (int i = 0; i < 16; i++) begin
      if (mfree[i]) return i;
    end
    return -1;
  endfunction

  function automatic bit exp_req_ready();
    return !tx_pause && mnfree != 0;
  endfunction

  function automatic bit exp_rep_ready();
    return m_in_data && !tx_pause;
  endfunction

  // Advance the model by one cycle using the currently driven inputs,
  // then let the DUT take the same clock edge.
  task automatic tick();
    int  t;
    bit  rel_free;
    bit  rel_busy;
    logic [7:0] t8;
    e_reqq = 1'b0;
    e_memq = 1'b0;
    m_hdr = 1'b0;
    m_beat = 1'b0;
    rel_free = tag_rel_valid && mfree[tag_rel];
    rel_busy = tag_rel_valid && !mfree[tag_rel];
    if (req_valid && exp_req_ready()) begin
      t = lowest_free();
      t8 = 8'(t);
`ifdef IPG_MSG_SEQ_EN
      e_req_chunk = {req_opcode & MASK, t8, req_len, 8'(m_seq), req_addr[31:0]};
      m_seq = (m_seq + 1) % 256;
`else
      e_req_chunk = {req_opcode & MASK, t8, req_len, req_addr};
`endif
      mfree[t] = 1'b0;
      mnfree--;
      e_reqq = 1'b1;
    end
    if (rel_busy) begin
      mfree[tag_rel] = 1'b1;
      mnfree++;
    end
    if (rel_free) m_terr = 1'b1;
    if (rep_valid && !tx_pause) begin
      if (!m_in_data) begin
        e_rep_chunk = {8'h02, rep_tag, rep_len, 40'h0};
        m_in_data = 1'b1;
        m_len = rep_len;
        m_cnt = 0;
        m_hdr = 1'b1;
      end else begin
        e_rep_chunk = rep_data;
        m_cnt++;
        m_beat = 1'b1;
        if (rep_last) begin
          if (m_cnt != m_len) m_lerr = 1'b1;
          m_in_data = 1'b0;
        end
      end
      e_memq = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0;
    req_opcode = '0;
    req_addr = '0;
    req_len = '0;
    rep_valid = 1'b0;
    rep_data = '0;
    rep_last = 1'b0;
    rep_tag = '0;
    rep_len = '0;
    tag_rel_valid = 1'b0;
    tag_rel = '0;
    tx_pause = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mreset();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks += 7;
    if (reqq_write !== 1'b0) begin errors++; $display("FAIL rst_reqq got %b exp 0", reqq_write); end
    if (memq_write !== 1'b0) begin errors++; $display("FAIL rst_memq got %b exp 0", memq_write); end
    if (ipg_req_chunk !== 64'h0) begin errors++; $display("FAIL rst_reqchunk got %h exp 0", ipg_req_chunk); end
    if (ipg_reply_chunk !== 64'h0) begin errors++; $display("FAIL rst_repchunk got %h exp 0", ipg_reply_chunk); end
    if (tags_free !== 5'd16) begin errors++; $display("FAIL rst_tags_free got %0d exp 16", tags_free); end
    if ({rep_len_err, tag_err} !== 2'b00) begin errors++; $display("FAIL rst_errs got %b exp 00", {rep_len_err, tag_err}); end
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_request();
    req_valid = 1'b1;
    req_opcode = 8'h01;
    req_addr = 40'h12_3456_789A;
    req_len = 8'd4;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL req_ready got %b exp 1", req_ready); end
    tick();
    req_valid = 1'b0;
    checks += 3;
    if (reqq_write !== 1'b1) begin errors++; $display("FAIL req_strobe got %b exp 1", reqq_write); end
    if (ipg_req_chunk !== e_req_chunk) begin errors++; $display("FAIL req_chunk got %h exp %h", ipg_req_chunk, e_req_chunk); end
    if (tags_free !== 5'd15) begin errors++; $display("FAIL req_tags_free got %0d exp 15", tags_free); end
`ifndef IPG_MSG_SEQ_EN
    checks++;
    if (ipg_req_chunk !== 64'h0100_0412_3456_789A) begin errors++; $display("FAIL req_literal got %h exp 0100041234567 89a", ipg_req_chunk); end
`endif
    tick();
    checks++;
    if (reqq_write !== 1'b0) begin errors++; $display("FAIL req_one_shot got %b exp 0", reqq_write); end
  endtask

  task automatic release_then_request(input int tg);
    tag_rel_valid = 1'b1;
    tag_rel = 4'(tg);
    req_valid = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL rel_stall_ready tag %0d got %b exp 0", tg, req_ready); end
    tick();
    tag_rel_valid = 1'b0;
    checks += 2;
    if (reqq_write !== 1'b0) begin errors++; $display("FAIL rel_stall_strobe got %b exp 0", reqq_write); end
    if (tags_free !== 5'd1) begin errors++; $display("FAIL rel_tags_free got %0d exp 1", tags_free); end
    tick();
    req_valid = 1'b0;
    checks += 3;
    if (reqq_write !== 1'b1) begin errors++; $display("FAIL rel_alloc_strobe got %b exp 1", reqq_write); end
    if (ipg_req_chunk[55:48] !== 8'(tg)) begin errors++; $display("FAIL rel_alloc_tag got %0d exp %0d", ipg_req_chunk[55:48], tg); end
    if (tags_free !== 5'd0) begin errors++; $display("FAIL rel_realloc_free got %0d exp 0", tags_free); end
  endtask

  task automatic test_tag_exhaust();
    logic [63:0] r;
    for (int i = 0; i < 15; i++) begin
      r = {$urandom, $urandom};
      req_valid = 1'b1;
      req_opcode = r[63:56];
      req_addr = r[39:0];
      req_len = r[47:40];
      tick();
      checks++;
      if (reqq_write !== 1'b1 || ipg_req_chunk !== e_req_chunk) begin
        errors++;
        $display("FAIL exhaust_req%0d got %b/%h exp 1/%h", i, reqq_write, ipg_req_chunk, e_req_chunk);
      end
    end
    #1;
    checks += 2;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL exhaust_ready got %b exp 0", req_ready); end
    if (tags_free !== 5'd0) begin errors++; $display("FAIL exhaust_free got %0d exp 0", tags_free); end
    release_then_request(5);
    release_then_request(0);
    tag_rel_valid = 1'b1;
    tag_rel = 4'd3;
    tick();
    checks += 2;
    if (tag_err !== 1'b0) begin errors++; $display("FAIL tag_err_early got %b exp 0", tag_err); end
    if (tags_free !== 5'd1) begin errors++; $display("FAIL rel3_free got %0d exp 1", tags_free); end
    tick();
    tag_rel_valid = 1'b0;
    checks += 2;
    if (tag_err !== 1'b1) begin errors++; $display("FAIL tag_err got %b exp 1", tag_err); end
    if (tags_free !== 5'd1) begin errors++; $display("FAIL dup_rel_free got %0d exp 1", tags_free); end
  endtask

  task automatic test_reply();
    logic [63:0] d[3];
    for (int i = 0; i < 3; i++) d[i] = {$urandom, $urandom};
    rep_valid = 1'b1;
    rep_tag = 8'h07;
    rep_len = 8'd3;
    rep_data = d[0];
    #1;
    checks++;
    if (rep_ready !== 1'b0) begin errors++; $display("FAIL rep_idle_ready got %b exp 0", rep_ready); end
    tick();
    checks++;
    if (memq_write !== 1'b1 || ipg_reply_chunk !== 64'h0207_0300_0000_0000) begin
      errors++;
      $display("FAIL rep_header got %b/%h exp 1/0207030000000000", memq_write, ipg_reply_chunk);
    end
    for (int b = 0; b < 3; b++) begin
      rep_data = d[b];
      rep_last = (b == 2);
      #1;
      checks++;
      if (rep_ready !== 1'b1) begin errors++; $display("FAIL rep_ready%0d got %b exp 1", b, rep_ready); end
      tick();
      checks++;
      if (memq_write !== 1'b1 || ipg_reply_chunk !== d[b]) begin
        errors++;
        $display("FAIL rep_beat%0d got %b/%h exp 1/%h", b, memq_write, ipg_reply_chunk, d[b]);
      end
    end
    rep_valid = 1'b0;
    rep_last = 1'b0;
    tick();
    checks += 2;
    if (memq_write !== 1'b0) begin errors++; $display("FAIL rep_end_strobe got %b exp 0", memq_write); end
    if (rep_len_err !== 1'b0) begin errors++; $display("FAIL rep_len_ok got %b exp 0", rep_len_err); end
  endtask

  task automatic test_pause();
    logic [63:0] d[4];
    for (int i = 0; i < 4; i++) d[i] = {$urandom, $urandom};
    rep_valid = 1'b1;
    rep_tag = 8'h09;
    rep_len = 8'd4;
    rep_data = d[0];
    tick();
    tick();
    checks++;
    if (ipg_reply_chunk !== d[0]) begin errors++; $display("FAIL pause_b0 got %h exp %h", ipg_reply_chunk, d[0]); end
    tx_pause = 1'b1;
    rep_data = d[1];
    req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (rep_ready !== 1'b0 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL pause_ready%0d got %b%b exp 00", c, rep_ready, req_ready);
      end
      tick();
      checks++;
      if (memq_write !== 1'b0 || reqq_write !== 1'b0) begin
        errors++;
        $display("FAIL pause_strobe%0d got %b%b exp 00", c, memq_write, reqq_write);
      end
    end
    tx_pause = 1'b0;
    req_valid = 1'b0;
    for (int b = 1; b < 4; b++) begin
      rep_data = d[b];
      rep_last = (b == 3);
      tick();
      checks++;
      if (memq_write !== 1'b1 || ipg_reply_chunk !== d[b]) begin
        errors++;
        $display("FAIL pause_resume%0d got %b/%h exp 1/%h", b, memq_write, ipg_reply_chunk, d[b]);
      end
    end
    rep_valid = 1'b0;
    rep_last = 1'b0;
    tick();
    checks++;
    if (memq_write !== 1'b0 || rep_len_err !== 1'b0) begin
      errors++;
      $display("FAIL pause_tail got %b%b exp 00", memq_write, rep_len_err);
    end
  endtask

  task automatic test_len_err_reset();
    do_reset();
    rep_valid = 1'b1;
    rep_tag = 8'h11;
    rep_len = 8'd2;
    rep_data = 64'hDEAD_BEEF_0000_0001;
    rep_last = 1'b1;
    tick();
    tick();
    rep_valid = 1'b0;
    rep_last = 1'b0;
    checks++;
    if (rep_len_err !== 1'b1) begin errors++; $display("FAIL len_err got %b exp 1", rep_len_err); end
    rep_valid = 1'b1;
    rep_len = 8'd5;
    req_valid = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_inputs();
    mreset();
    #1;
    checks += 5;
    if ({reqq_write, memq_write} !== 2'b00) begin errors++; $display("FAIL mid_rst_strobes got %b exp 00", {reqq_write, memq_write}); end
    if (ipg_req_chunk !== 64'h0 || ipg_reply_chunk !== 64'h0) begin errors++; $display("FAIL mid_rst_chunks got %h %h exp 0 0", ipg_req_chunk, ipg_reply_chunk); end
    if (tags_free !== 5'd16) begin errors++; $display("FAIL mid_rst_free got %0d exp 16", tags_free); end
    if ({rep_len_err, tag_err} !== 2'b00) begin errors++; $display("FAIL mid_rst_errs got %b exp 00", {rep_len_err, tag_err}); end
    if (rep_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_idle got %b exp 0", rep_ready); end
  endtask

  task automatic test_random();
    int          phase;
    int          nbeats;
    int          idx;
    logic [63:0] r;
    phase = 0;
    nbeats = 0;
    idx = 0;
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      r = {$urandom, $urandom};
      tx_pause = ($urandom_range(0, 4) == 0);
      req_valid = $urandom_range(0, 1) == 1;
      req_opcode = r[63:56];
      req_addr = r[39:0];
      req_len = r[47:40];
      tag_rel_valid = ($urandom_range(0, 2) == 0);
      tag_rel = 4'($urandom_range(0, 15));
      rep_data = {$urandom, $urandom};
      if (phase == 0) begin
        rep_last = 1'b0;
        rep_valid = 1'b0;
        if ($urandom_range(0, 2) == 0) begin
          rep_valid = 1'b1;
          rep_tag = 8'($urandom);
          rep_len = 8'($urandom_range(0, 5));
          nbeats = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6)
                   : (rep_len == 0 ? 1 : int'(rep_len));
          idx = 0;
          phase = 1;
        end
      end else if (phase == 1) begin
        rep_valid = 1'b1;
      end else begin
        rep_valid = $urandom_range(0, 3) != 0;
        rep_last = (idx == nbeats - 1);
      end
      #1;
      checks += 2;
      if (req_ready !== exp_req_ready()) begin errors++; $display("FAIL rnd_req_ready c%0d got %b exp %b", cyc, req_ready, exp_req_ready()); end
      if (rep_ready !== exp_rep_ready()) begin errors++; $display("FAIL rnd_rep_ready c%0d got %b exp %b", cyc, rep_ready, exp_rep_ready()); end
      tick();
      if (m_hdr) phase = 2;
      if (m_beat) begin
        idx++;
        if (rep_last) phase = 0;
      end
      checks += 5;
      if (reqq_write !== e_reqq || (e_reqq && ipg_req_chunk !== e_req_chunk)) begin
        errors++;
        $display("FAIL rnd_req c%0d got %b/%h exp %b/%h", cyc, reqq_write, ipg_req_chunk, e_reqq, e_req_chunk);
      end
      if (memq_write !== e_memq || (e_memq && ipg_reply_chunk !== e_rep_chunk)) begin
        errors++;
        $display("FAIL rnd_rep c%0d got %b/%h exp %b/%h", cyc, memq_write, ipg_reply_chunk, e_memq, e_rep_chunk);
      end
      if (tags_free !== 5'(mnfree)) begin errors++; $display("FAIL rnd_free c%0d got %0d exp %0d", cyc, tags_free, mnfree); end
      if (rep_len_err !== m_lerr) begin errors++; $display("FAIL rnd_len_err c%0d got %b exp %b", cyc, rep_len_err, m_lerr); end
      if (tag_err !== m_terr) begin errors++; $display("FAIL rnd_tag_err c%0d got %b exp %b", cyc, tag_err, m_terr); end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    mreset();
    test_reset();
    test_request();
    test_tag_exhaust();
    test_reply();
    test_pause();
    test_len_err_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
